// File: rtl/panel_loader.sv
// Front-panel program loader: turns a byte stream into 12-bit words and plays
// each one into the CPU switch inputs as a deposit / increment-P sequence.
module panel_loader #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [11:0] nsw,
  output logic        ndep_sw,
  output logic        nincp_sw,
  output logic        nstart_sw,
  output logic        busy,
  output logic [11:0] word_count
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {LO, HI, SETUP, DEP, HOLD, INC, RECOVER, START} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  low_q, low_d;
  logic        last_q, last_d;
  logic [11:0] nsw_d;
  logic [11:0] word_count_d;
  logic        xfer;

  assign xfer = in_valid & in_ready;

  // The counter is loaded with duration-1 on entry; a state exits on the edge
  // where it reads zero, so each state lasts exactly its programmed cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    low_d        = low_q;
    last_d       = last_q;
    nsw_d        = nsw;
    word_count_d = word_count;
    case (state_q)
      LO: begin
        if (xfer) begin
          low_d   = in_data;
          state_d = HI;
        end
      end
      HI: begin
        if (xfer) begin
          nsw_d   = ~{in_data[3:0], low_q};
          last_d  = in_data[7];
          cnt_d   = GAP_LOAD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_LOAD;
          state_d = DEP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DEP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = GAP_LOAD;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_LOAD;
          state_d = INC;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      INC: begin
        if (cnt_q == 8'd0) begin
          word_count_d = word_count + 12'd1;
          cnt_d        = GAP_LOAD;
          state_d      = RECOVER;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 8'd0) begin
          if (last_q) begin
            cnt_d   = PULSE_LOAD;
            state_d = START;
          end else begin
            nsw_d   = 12'hFFF;
            state_d = LO;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      START: begin
        if (cnt_q == 8'd0) begin
          nsw_d   = 12'hFFF;
          last_d  = 1'b0;
          state_d = LO;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        nsw_d   = 12'hFFF;
        state_d = LO;
      end
    endcase
  end

  // Switch outputs are decoded from the next state and registered, so the CPU
  // only ever sees glitch-free flop outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= LO;
      cnt_q      <= 8'd0;
      low_q      <= 8'd0;
      last_q     <= 1'b0;
      nsw        <= 12'hFFF;
      ndep_sw    <= 1'b1;
      nincp_sw   <= 1'b1;
      nstart_sw  <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      word_count <= 12'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      low_q      <= low_d;
      last_q     <= last_d;
      nsw        <= nsw_d;
      ndep_sw    <= (state_d != DEP);
      nincp_sw   <= (state_d != INC);
      nstart_sw  <= (state_d != START);
      in_ready   <= (state_d == LO) || (state_d == HI);
      busy       <= (state_d != LO);
      word_count <= word_count_d;
    end
  end

endmodule

// File: tb/tb_panel_loader.sv
// Directed bench for panel_loader: default-timing instance plus a fast
// instance (PULSE_CYCLES=1, GAP_CYCLES=1) sharing clock and reset.
module tb_panel_loader;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        v = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        sel = 1'b0;

  logic        d_valid, d_ready, d_ndep, d_nincp, d_nstart, d_busy;
  logic [11:0] d_nsw, d_wc;
  logic        f_valid, f_ready, f_ndep, f_nincp, f_nstart, f_busy;
  logic [11:0] f_nsw, f_wc;

  logic [28:0] obs;
  logic        o_ready;

  int checks = 0;
  int failures = 0;
  int overlaps = 0;
  logic [11:0] wc_d = 12'd0;
  logic [11:0] wc_f = 12'd0;

  typedef struct packed {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [11:0] word;
    logic        last;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  assign d_valid = v & ~sel;
  assign f_valid = v & sel;

  panel_loader dut_d (
    .clk(clk), .nrst(nrst), .in_valid(d_valid), .in_data(din), .in_ready(d_ready),
    .nsw(d_nsw), .ndep_sw(d_ndep), .nincp_sw(d_nincp), .nstart_sw(d_nstart),
    .busy(d_busy), .word_count(d_wc)
  );

  panel_loader #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_f (
    .clk(clk), .nrst(nrst), .in_valid(f_valid), .in_data(din), .in_ready(f_ready),
    .nsw(f_nsw), .ndep_sw(f_ndep), .nincp_sw(f_nincp), .nstart_sw(f_nstart),
    .busy(f_busy), .word_count(f_wc)
  );

  assign obs = sel ? {f_ready, f_busy, f_nsw, f_ndep, f_nincp, f_nstart, f_wc}
                   : {d_ready, d_busy, d_nsw, d_ndep, d_nincp, d_nstart, d_wc};
  assign o_ready = obs[28];

  always @(negedge clk) begin
    if (int'(!d_ndep) + int'(!d_nincp) + int'(!d_nstart) > 1) overlaps++;
    if (int'(!f_ndep) + int'(!f_nincp) + int'(!f_nstart) > 1) overlaps++;
  end

  function automatic logic [28:0] pack(input logic rdy, input logic bsy, input logic [11:0] sw,
                                       input logic dep, input logic inc, input logic st,
                                       input logic [11:0] wc);
    return {rdy, bsy, sw, dep, inc, st, wc};
  endfunction

  task automatic checkOutput(input string name, input logic [28:0] act, input logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one byte and returns 1ns after the edge that transfers it.
  task automatic applyStimulus(input logic [7:0] b, input bit keep);
    int n = 0;
    din = b;
    v = 1'b1;
    while (!o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    if (!keep) v = 1'b0;
  endtask

  // Entered 1ns after E0; checks every cycle through the return to LO.
  task automatic checkWord(input string name, input logic [11:0] word, input logic last,
                           input logic [11:0] base);
    int g = sel ? 1 : 4;
    int p = sel ? 1 : 4;
    int end_k = 3 * g + 2 * p + (last ? p : 0);
    logic [11:0] next_wc = base + 12'd1;
    for (int k = 0; k <= end_k; k++) begin
      checkOutput($sformatf("%s k=%0d", name, k), obs,
                  pack(k == end_k, k != end_k, (k == end_k) ? 12'hFFF : ~word,
                       !(k >= g && k < g + p),
                       !(k >= 2 * g + p && k < 2 * g + 2 * p),
                       !(last && k >= 3 * g + 2 * p && k < 3 * g + 3 * p),
                       (k >= 2 * g + 2 * p) ? next_wc : base));
      if (k < end_k) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    vecs[0] = '{lo: 8'h23, hi: 8'h01, word: 12'h123, last: 1'b0};
    vecs[1] = '{lo: 8'h05, hi: 8'h80, word: 12'h005, last: 1'b1};
    vecs[2] = '{lo: 8'hAB, hi: 8'h7C, word: 12'hCAB, last: 1'b0};
    vecs[3] = '{lo: 8'h00, hi: 8'hF0, word: 12'h000, last: 1'b1};

    @(posedge clk); #1;
    sel = 1'b0; #1;
    checkOutput("reset_d", obs, pack(1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1, 12'd0));
    sel = 1'b1; #1;
    checkOutput("reset_f", obs, pack(1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1, 12'd0));
    sel = 1'b0;
    nrst = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_d", obs, pack(1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1, 12'd0));

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].lo, 1'b0);
      applyStimulus(vecs[i].hi, 1'b0);
      checkWord($sformatf("vec%0d", i), vecs[i].word, vecs[i].last, wc_d);
      wc_d = wc_d + 12'd1;
    end

    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h02, 1'b1);
    din = 8'h22;
    checkWord("bp_word0", 12'h211, 1'b0, wc_d);
    wc_d = wc_d + 12'd1;
    @(posedge clk); #1;
    checkOutput("bp_third_byte", obs, pack(1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b1, wc_d));
    din = 8'h03;
    @(posedge clk); #1;
    v = 1'b0;
    checkWord("bp_word1", 12'h322, 1'b0, wc_d);
    wc_d = wc_d + 12'd1;

    applyStimulus(8'h34, 1'b0);
    applyStimulus(8'h02, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("pre_reset_dep", obs, pack(1'b0, 1'b1, 12'hDCB, 1'b0, 1'b1, 1'b1, wc_d));
    #2 nrst = 1'b0;
    #1;
    checkOutput("async_reset", obs, pack(1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1, 12'd0));
    #2 nrst = 1'b1;
    wc_d = 12'd0;
    @(posedge clk); #1;
    applyStimulus(8'h55, 1'b0);
    #2 nrst = 1'b0;
    #2 nrst = 1'b1;
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h0F, 1'b0);
    checkWord("after_reset", 12'hFFF, 1'b0, wc_d);
    wc_d = wc_d + 12'd1;

    sel = 1'b1;
    applyStimulus(8'h9A, 1'b0);
    applyStimulus(8'h05, 1'b0);
    checkWord("fast_word", 12'h59A, 1'b0, wc_f);
    wc_f = wc_f + 12'd1;
    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'h8E, 1'b0);
    checkWord("fast_last", 12'hE3C, 1'b1, wc_f);
    wc_f = wc_f + 12'd1;

    #2 nrst = 1'b0;
    #2 nrst = 1'b1;
    wc_f = 12'd0;
    for (int i = 0; i < 4095; i++) begin
      logic [11:0] w;
      w = 12'(i);
      applyStimulus(w[7:0], 1'b1);
      applyStimulus({4'h0, w[11:8]}, 1'b1);
    end
    v = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("wrap_4095", obs, pack(1'b1, 1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1, 12'd4095));
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'h0F, 1'b0);
    checkWord("wrap_last", 12'hF77, 1'b0, 12'd4095);

    checkOutput("no_overlap", 29'(overlaps), 29'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
